// File: rtl/conversor_bcd_secuencial.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock) with
// valid/ready handshakes and overflow flag. Define CONVERSION_SIGNO_EN for signed input.
module conversor_bcd_secuencial #(
    parameter int unsigned ANCHO_BIN = 8,
    parameter int unsigned DIGITOS   = 3
) (
    input  logic                   reloj,
    input  logic                   reinicio,
    input  logic                   entradaValida,
    input  logic [ANCHO_BIN-1:0]   resultadoEntrada,
    output logic                   listoEntrada,
    output logic [4*DIGITOS-1:0]   bcd,
    output logic                   salidaValida,
    input  logic                   salidaAceptada,
    output logic                   desborde
`ifdef CONVERSION_SIGNO_EN
    ,
    output logic                   negativo
`endif
);

    localparam int unsigned AnchoBcd = 4 * DIGITOS;
    localparam int unsigned AnchoCnt = $clog2(ANCHO_BIN);
    localparam logic [AnchoCnt-1:0] CntUltimo = AnchoCnt'(ANCHO_BIN - 1);

    typedef enum logic [1:0] {StInactivo, StConvierte, StEntrega} estado_e;

    estado_e               estado_q, estado_d;
    logic [ANCHO_BIN-1:0]  desp_q, desp_d;
    logic [AnchoBcd-1:0]   acum_q, acum_d;
    logic [AnchoCnt-1:0]   cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [AnchoBcd-1:0]   bcd_q, bcd_d;
    logic                  valida_q, valida_d;
    logic                  desborde_q, desborde_d;

    logic [ANCHO_BIN-1:0]  magnitud;
    logic [AnchoBcd-1:0]   acum_corr;
    logic [AnchoBcd-1:0]   acum_desp;

`ifdef CONVERSION_SIGNO_EN
    logic signo_q, signo_d;
    logic negativo_q, negativo_d;

    // Two's-complement negation of the most negative value wraps to 2^(ANCHO_BIN-1).
    assign magnitud = resultadoEntrada[ANCHO_BIN-1] ? -resultadoEntrada : resultadoEntrada;
`else
    assign magnitud = resultadoEntrada;
`endif

    // Add-3 correction per digit, no carry between digits.
    always_comb begin
        acum_corr = acum_q;
        for (int i = 0; i < DIGITOS; i++) begin
            if (acum_q[4*i +: 4] >= 4'd5) begin
                acum_corr[4*i +: 4] = acum_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign acum_desp = {acum_corr[AnchoBcd-2:0], desp_q[ANCHO_BIN-1]};

    always_comb begin
        estado_d   = estado_q;
        desp_d     = desp_q;
        acum_d     = acum_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        valida_d   = valida_q;
        desborde_d = desborde_q;
`ifdef CONVERSION_SIGNO_EN
        signo_d    = signo_q;
        negativo_d = negativo_q;
`endif
        unique case (estado_q)
            StInactivo: begin
                if (entradaValida) begin
                    desp_d   = magnitud;
                    acum_d   = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
`ifdef CONVERSION_SIGNO_EN
                    signo_d  = resultadoEntrada[ANCHO_BIN-1];
`endif
                    estado_d = StConvierte;
                end
            end
            StConvierte: begin
                desp_d = {desp_q[ANCHO_BIN-2:0], 1'b0};
                acum_d = acum_desp;
                ovf_d  = ovf_q | acum_corr[AnchoBcd-1];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntUltimo) begin
                    bcd_d      = acum_desp;
                    desborde_d = ovf_d;
                    valida_d   = 1'b1;
`ifdef CONVERSION_SIGNO_EN
                    negativo_d = signo_q;
`endif
                    estado_d   = StEntrega;
                end
            end
            StEntrega: begin
                if (salidaAceptada) begin
                    valida_d = 1'b0;
                    estado_d = StInactivo;
                end
            end
            default: estado_d = StInactivo;
        endcase
    end

    always_ff @(posedge reloj or negedge reinicio) begin
        if (!reinicio) begin
            estado_q   <= StInactivo;
            desp_q     <= '0;
            acum_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            valida_q   <= 1'b0;
            desborde_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            desp_q     <= desp_d;
            acum_q     <= acum_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            valida_q   <= valida_d;
            desborde_q <= desborde_d;
        end
    end

`ifdef CONVERSION_SIGNO_EN
    always_ff @(posedge reloj or negedge reinicio) begin
        if (!reinicio) begin
            signo_q    <= 1'b0;
            negativo_q <= 1'b0;
        end else begin
            signo_q    <= signo_d;
            negativo_q <= negativo_d;
        end
    end

    assign negativo = negativo_q;
`endif

    assign listoEntrada = (estado_q == StInactivo);
    assign bcd          = bcd_q;
    assign salidaValida = valida_q;
    assign desborde     = desborde_q;

endmodule
